// File: rtl/atriusb_bridge_arbiter_pkg.sv
// Shared definitions for the FX2 IN-endpoint bridge arbiter: FSM state
// encodings, default packet/flush sizing and a constant-width helper.
package atriusb_bridge_pkg;

    localparam int DEF_PKT_BYTES     = 512;
    localparam int DEF_FLUSH_TIMEOUT = 4096;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_STREAM = 3'd2,
        ST_STALL  = 3'd3,
        ST_PKTEND = 3'd4
    } state_t;

    // Number of bits needed to index 'value' items (ceil(log2(value))).
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/atriusb_bridge_arbiter_if.sv
// Source-side and FX2-writer-side signals of the bridge arbiter. The
// arbiter uses the slave view; whoever drives the sources and the FX2
// ready uses the master view.
interface atriusb_bridge_arbiter_if #(
    parameter int NSRC = 2
);
    logic [NSRC-1:0]   src_en_i;
    logic [NSRC-1:0]   src_pending_i;
    logic [8*NSRC-1:0] src_dat_i;
    logic [NSRC-1:0]   src_done_i;
    logic [NSRC-1:0]   src_rd_o;
    logic [7:0]        out_dat_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              pktend_o;
    logic [1:0]        grant_o;
    logic              busy_o;

    modport slave (
        input  src_en_i, src_pending_i, src_dat_i, src_done_i, out_ready_i,
        output src_rd_o, out_dat_o, out_valid_o, pktend_o, grant_o, busy_o
    );

    modport master (
        output src_en_i, src_pending_i, src_dat_i, src_done_i, out_ready_i,
        input  src_rd_o, out_dat_o, out_valid_o, pktend_o, grant_o, busy_o
    );
endinterface

// File: rtl/atriusb_bridge_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index after 'last',
// wrapping, with 'last' itself taking lowest priority.
module atriusb_rr_pick #(
    parameter int NSRC = 2
) (
    input  logic [NSRC-1:0] req,
    input  logic [1:0]      last,
    output logic [1:0]      gnt_idx,
    output logic            any
);

    // Walk from farthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        // NOTE: outputs get defaults before the loop so every path assigns them and no latch is inferred.
        gnt_idx = 2'd0;
        any     = 1'b0;
        for (int k = NSRC; k >= 1; k--) begin
            if (req[(int'(last) + k) % NSRC]) begin
                gnt_idx = 2'((int'(last) + k) % NSRC);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/atriusb_bridge_arbiter.sv
// Round-robin arbiter sharing one FX2 IN-endpoint byte stream between up
// to four byte sources. One source owns the stream for a whole USB packet;
// short packets are committed with pktend on end of event or long stall.
module atriusb_bridge_arbiter
    import atriusb_bridge_pkg::*;
#(
    parameter int NSRC          = 2,
    parameter int PKT_BYTES     = DEF_PKT_BYTES,
    parameter int FLUSH_TIMEOUT = DEF_FLUSH_TIMEOUT
) (
    input  logic                     phy_clk_i,
    input  logic                     rst_n_i,
    atriusb_bridge_arbiter_if.slave  bus
);

    localparam int CW = clogb2(PKT_BYTES) + 1;

    state_t          r_state;
    logic [1:0]      r_sel;
    logic [1:0]      r_last;
    logic [CW-1:0]   r_byte_cnt;
    logic [15:0]     r_stall_cnt;

    logic [NSRC-1:0] w_req;
    logic [1:0]      w_pick;
    logic            w_any;
    logic [7:0]      w_sel_dat;
    logic            w_sel_pending;
    logic            w_sel_done;
    logic            w_valid;
    logic            w_xfer;
    logic [CW-1:0]   w_byte_cnt_nxt;

    assign w_req = bus.src_en_i & bus.src_pending_i;

    atriusb_rr_pick #(.NSRC(NSRC)) u_pick (
        .req     (w_req),
        .last    (r_last),
        .gnt_idx (w_pick),
        .any     (w_any)
    );

    // Select the granted source's byte, pending and done flags.
    always_comb begin
        w_sel_dat     = 8'h00;
        w_sel_pending = 1'b0;
        w_sel_done    = 1'b0;
        for (int n = 0; n < NSRC; n++) begin
            if (r_sel == 2'(n)) begin
                w_sel_dat     = bus.src_dat_i[8*n +: 8];
                w_sel_pending = bus.src_pending_i[n];
                w_sel_done    = bus.src_done_i[n];
            end
        end
    end

    // Stream outputs are combinational from registered state and the sources.
    always_comb begin
        w_valid        = (r_state == ST_STREAM) && w_sel_pending;
        w_xfer         = w_valid && bus.out_ready_i;
        w_byte_cnt_nxt = r_byte_cnt + CW'(w_xfer);
        bus.out_valid_o = w_valid;
        bus.out_dat_o   = w_valid ? w_sel_dat : 8'h00;
        bus.pktend_o    = (r_state == ST_PKTEND) && bus.out_ready_i;
        bus.src_rd_o    = '0;
        for (int n = 0; n < NSRC; n++) begin
            if (r_sel == 2'(n)) begin
                bus.src_rd_o[n] = w_xfer;
            end
        end
    end

    assign bus.grant_o = r_sel;
    assign bus.busy_o  = (r_state != ST_IDLE);

    // Packet FSM with byte and stall counters; re-arbitrates only in IDLE.
    always_ff @(posedge phy_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
            r_state     <= ST_IDLE;
            r_sel       <= 2'd0;
            r_last      <= 2'(NSRC - 1);
            r_byte_cnt  <= '0;
            r_stall_cnt <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_pick;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    r_byte_cnt  <= '0;
                    r_stall_cnt <= 16'd0;
                    r_state     <= ST_STREAM;
                end
                ST_STREAM: begin
                    r_byte_cnt <= w_byte_cnt_nxt;
                    if (w_xfer && (w_byte_cnt_nxt == CW'(PKT_BYTES))) begin
                        // Full packet: the FX2 commits it itself, a coincident done is absorbed.
                        r_last  <= r_sel;
                        r_state <= ST_IDLE;
                    end else if (w_sel_done) begin
                        if (w_byte_cnt_nxt != '0) begin
                            r_state <= ST_PKTEND;
                        end else begin
                            r_last  <= r_sel;
                            r_state <= ST_IDLE;
                        end
                    end else if (!w_sel_pending) begin
                        r_state <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (r_stall_cnt != 16'hFFFF) begin
                        r_stall_cnt <= r_stall_cnt + 16'd1;
                    end
                    if (w_sel_pending) begin
                        r_stall_cnt <= 16'd0;
                        r_state     <= ST_STREAM;
                    end else if (w_sel_done) begin
                        if (r_byte_cnt != '0) begin
                            r_state <= ST_PKTEND;
                        end else begin
                            // Empty grant released: rotate past this source like any other release.
                            r_last  <= r_sel;
                            r_state <= ST_IDLE;
                        end
                    end else if (r_stall_cnt == 16'(FLUSH_TIMEOUT - 1)) begin
                        r_state <= ST_PKTEND;
                    end
                end
                ST_PKTEND: begin
                    if (bus.out_ready_i) begin
                        r_last  <= r_sel;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atriusb_bridge_arbiter.sv
// Self-checking bench for atriusb_bridge_arbiter: queue-based byte sources,
// a cycle-level reference model of the packet rules, a per-source byte
// scoreboard, and directed scenarios followed by randomized traffic.
module tb_atriusb_bridge_arbiter;

    localparam int NSRC = 2;
    localparam int PKT  = 512;
    localparam int FT   = 4096;

    localparam int M_IDLE   = 0;
    localparam int M_ARM    = 1;
    localparam int M_XFER   = 2;
    localparam int M_WAIT   = 3;
    localparam int M_COMMIT = 4;

    logic phy_clk_i = 1'b0;
    logic rst_n_i   = 1'b0;

    always #5 phy_clk_i = ~phy_clk_i;

    atriusb_bridge_arbiter_if #(.NSRC(NSRC)) bus ();

    atriusb_bridge_arbiter #(
        .NSRC          (NSRC),
        .PKT_BYTES     (PKT),
        .FLUSH_TIMEOUT (FT)
    ) dut (
        .phy_clk_i (phy_clk_i),
        .rst_n_i   (rst_n_i),
        .bus       (bus)
    );

    // Bookkeeping
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Sources
    logic [7:0]      src_q [NSRC][$];
    int              push_cnt [NSRC];
    int              rx_cnt   [NSRC];
    bit              pulse_done [NSRC];
    bit              auto_done  [NSRC];
    bit              ready_rand = 1'b0;
    logic [NSRC-1:0] en_mask = '1;

    // Reference model
    int m_ph, m_sel, m_last, m_sent, m_quiet;

    // Scenario statistics
    int st_rd [NSRC];
    int st_pktend;
    int grant_log [$];
    int first_rd_cyc, last_xfer_cyc, pktend_cyc;
    bit prev_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [7:0] gen(input int n, input int k);
        return 8'((k + 37 * n) & 255);
    endfunction

    function automatic int glog(input int i);
        return (grant_log.size() > i) ? grant_log[i] : -1;
    endfunction

    task automatic push(input int n, input int count);
        for (int i = 0; i < count; i++) begin
            src_q[n].push_back(gen(n, push_cnt[n]));
            push_cnt[n]++;
        end
    endtask

    task automatic clear_stats();
        for (int n = 0; n < NSRC; n++) st_rd[n] = 0;
        st_pktend     = 0;
        grant_log.delete();
        first_rd_cyc  = -1;
        last_xfer_cyc = 0;
        pktend_cyc    = 0;
    endtask

    task automatic model_reset();
        m_ph    = M_IDLE;
        m_sel   = 0;
        m_last  = NSRC - 1;
        m_sent  = 0;
        m_quiet = 0;
    endtask

    task automatic drive_inputs();
        for (int n = 0; n < NSRC; n++) begin
            bus.src_pending_i[n]    = (src_q[n].size() > 0);
            bus.src_dat_i[8*n +: 8] = (src_q[n].size() > 0) ? src_q[n][0] : 8'($urandom);
            bus.src_done_i[n]       = pulse_done[n] | (auto_done[n] && (src_q[n].size() == 1));
        end
        bus.src_en_i    = en_mask;
        bus.out_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Called mid-cycle: inputs are stable until the next rising edge.
    task automatic model_step(output logic [NSRC-1:0] rd_seen);
        logic [NSRC-1:0] pend, done, en, exp_rd;
        logic            rdy, exp_valid, exp_pktend, exp_busy, xfer;
        logic [7:0]      exp_dat;
        int              exp_grant;
        pend = bus.src_pending_i;
        done = bus.src_done_i;
        en   = bus.src_en_i;
        rdy  = bus.out_ready_i;
        exp_valid  = 1'b0;
        exp_pktend = 1'b0;
        exp_rd     = '0;
        exp_dat    = 8'h00;
        xfer       = 1'b0;
        if (!rst_n_i) model_reset();
        exp_busy  = (m_ph != M_IDLE);
        exp_grant = m_sel;
        if (rst_n_i) begin
            case (m_ph)
                M_IDLE: begin
                    for (int k = 1; k <= NSRC; k++) begin
                        if (en[(m_last + k) % NSRC] && pend[(m_last + k) % NSRC]) begin
                            m_sel = (m_last + k) % NSRC;
                            m_ph  = M_ARM;
                            break;
                        end
                    end
                end
                M_ARM: begin
                    m_sent  = 0;
                    m_quiet = 0;
                    m_ph    = M_XFER;
                end
                M_XFER: begin
                    exp_valid = pend[m_sel];
                    exp_dat   = exp_valid ? bus.src_dat_i[8*m_sel +: 8] : 8'h00;
                    xfer      = exp_valid && rdy;
                    if (xfer) begin
                        exp_rd[m_sel] = 1'b1;
                        m_sent++;
                    end
                    if (xfer && m_sent == PKT) begin
                        m_last = m_sel;
                        m_ph   = M_IDLE;
                    end else if (done[m_sel]) begin
                        if (m_sent != 0) m_ph = M_COMMIT;
                        else begin m_last = m_sel; m_ph = M_IDLE; end
                    end else if (!pend[m_sel]) begin
                        m_ph = M_WAIT;
                    end
                end
                M_WAIT: begin
                    if (pend[m_sel]) begin
                        m_quiet = 0;
                        m_ph    = M_XFER;
                    end else if (done[m_sel]) begin
                        if (m_sent != 0) m_ph = M_COMMIT;
                        else begin m_last = m_sel; m_ph = M_IDLE; end
                    end else if (m_quiet == FT - 1) begin
                        m_ph = M_COMMIT;
                    end else if (m_quiet < 65535) begin
                        m_quiet++;
                    end
                end
                M_COMMIT: begin
                    exp_pktend = rdy;
                    if (rdy) begin
                        m_last = m_sel;
                        m_ph   = M_IDLE;
                    end
                end
                default: m_ph = M_IDLE;
            endcase
        end
        check("out_valid", 32'(bus.out_valid_o), 32'(exp_valid));
        check("out_dat",   32'(bus.out_dat_o),   32'(exp_dat));
        check("src_rd",    32'(bus.src_rd_o),    32'(exp_rd));
        check("pktend",    32'(bus.pktend_o),    32'(exp_pktend));
        check("grant",     32'(bus.grant_o),     32'(exp_grant));
        check("busy",      32'(bus.busy_o),      32'(exp_busy));
        rd_seen = bus.src_rd_o;
        for (int n = 0; n < NSRC; n++) begin
            if (bus.src_rd_o[n]) begin
                check("sb_byte", 32'(bus.out_dat_o), 32'(gen(n, rx_cnt[n])));
                rx_cnt[n]++;
                st_rd[n]++;
                last_xfer_cyc = cyc;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
        end
        if (bus.pktend_o) begin
            st_pktend++;
            pktend_cyc = cyc;
        end
        if (bus.busy_o && !prev_busy) grant_log.push_back(int'(bus.grant_o));
        prev_busy = bus.busy_o;
    endtask

    // One clock: drive after the edge, check mid-cycle, let sources consume.
    task automatic tick();
        logic [NSRC-1:0] rd_seen;
        drive_inputs();
        @(negedge phy_clk_i);
        cyc++;
        model_step(rd_seen);
        @(posedge phy_clk_i);
        #1;
        for (int n = 0; n < NSRC; n++) begin
            if (rd_seen[n] && src_q[n].size() > 0) void'(src_q[n].pop_front());
            pulse_done[n] = 1'b0;
        end
    endtask

    // Asynchronous reset between edges; outputs must drop at once.
    task automatic do_reset();
        #2 rst_n_i = 1'b0;
        #1;
        check("rst_valid",  32'(bus.out_valid_o), 32'd0);
        check("rst_dat",    32'(bus.out_dat_o),   32'd0);
        check("rst_rd",     32'(bus.src_rd_o),    32'd0);
        check("rst_pktend", 32'(bus.pktend_o),    32'd0);
        check("rst_grant",  32'(bus.grant_o),     32'd0);
        check("rst_busy",   32'(bus.busy_o),      32'd0);
        @(posedge phy_clk_i);
        #1;
        tick();
        rst_n_i = 1'b1;
    endtask

    task automatic wait_busy_then_idle(input string tag, input int budget);
        int c;
        c = 0;
        while (!bus.busy_o && c < budget) begin tick(); c++; end
        while (bus.busy_o && c < budget) begin tick(); c++; end
        check({tag, "_in_time"}, 32'(c < budget), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c, start_cyc;
        for (int n = 0; n < NSRC; n++) begin
            push_cnt[n]   = 0;
            rx_cnt[n]     = 0;
            pulse_done[n] = 1'b0;
            auto_done[n]  = 1'b0;
        end
        model_reset();
        clear_stats();
        drive_inputs();
        @(posedge phy_clk_i);
        #1;

        // 1: single full packet from source 0, with IDLE-to-first-read latency
        do_reset();
        clear_stats();
        push(0, PKT);
        start_cyc = cyc + 1;
        wait_busy_then_idle("t1", 700);
        check("t1_bytes",   32'(st_rd[0]), 32'(PKT));
        check("t1_pktend",  32'(st_pktend), 32'd0);
        check("t1_latency", 32'(first_rd_cyc - start_cyc), 32'd2);
        check("t1_idle",    32'(bus.busy_o), 32'd0);

        // 2: round-robin with 50% backpressure
        do_reset();
        clear_stats();
        ready_rand = 1'b1;
        push(0, 2 * PKT);
        push(1, 2 * PKT);
        c = 0;
        while (!(src_q[0].size() == 0 && src_q[1].size() == 0 && !bus.busy_o) && c < 9000) begin
            tick();
            c++;
        end
        check("t2_in_time", 32'(c < 9000), 32'd1);
        check("t2_grants",  32'(grant_log.size()), 32'd4);
        check("t2_g0", 32'(glog(0)), 32'd0);
        check("t2_g1", 32'(glog(1)), 32'd1);
        check("t2_g2", 32'(glog(2)), 32'd0);
        check("t2_g3", 32'(glog(3)), 32'd1);
        check("t2_bytes0", 32'(st_rd[0]), 32'(2 * PKT));
        check("t2_bytes1", 32'(st_rd[1]), 32'(2 * PKT));
        check("t2_pktend", 32'(st_pktend), 32'd0);
        ready_rand = 1'b0;

        // 3: short event on source 1, then done coinciding with byte 512
        do_reset();
        clear_stats();
        auto_done[1] = 1'b1;
        push(1, 100);
        wait_busy_then_idle("t3a", 300);
        check("t3a_bytes",  32'(st_rd[1]), 32'd100);
        check("t3a_pktend", 32'(st_pktend), 32'd1);
        check("t3a_grant",  32'(glog(0)), 32'd1);
        check("t3a_gap",    32'(pktend_cyc - last_xfer_cyc), 32'd1);
        clear_stats();
        push(1, PKT);
        wait_busy_then_idle("t3b", 700);
        check("t3b_bytes",  32'(st_rd[1]), 32'(PKT));
        check("t3b_pktend", 32'(st_pktend), 32'd0);
        auto_done[1] = 1'b0;

        // 4: stall for 1000 cycles after 200 bytes, then resume to 512
        do_reset();
        clear_stats();
        push(0, 200);
        c = 0;
        while (st_rd[0] < 200 && c < 600) begin tick(); c++; end
        check("t4_first_in_time", 32'(c < 600), 32'd1);
        repeat (1000) tick();
        check("t4_hold_busy",  32'(bus.busy_o), 32'd1);
        check("t4_hold_grant", 32'(bus.grant_o), 32'd0);
        push(0, PKT - 200);
        wait_busy_then_idle("t4", 1000);
        check("t4_bytes",  32'(st_rd[0]), 32'(PKT));
        check("t4_pktend", 32'(st_pktend), 32'd0);
        check("t4_grants", 32'(grant_log.size()), 32'd1);

        // 5: stall timeout forces pktend, then the other source is granted
        do_reset();
        clear_stats();
        auto_done[1] = 1'b1;
        push(0, 200);
        push(1, 300);
        c = 0;
        while (st_pktend == 0 && c < FT + 1000) begin tick(); c++; end
        check("t5_flush_in_time", 32'(c < FT + 1000), 32'd1);
        check("t5_bytes0", 32'(st_rd[0]), 32'd200);
        check("t5_gap",    32'(pktend_cyc - last_xfer_cyc), 32'(FT + 2));
        c = 0;
        while ((bus.busy_o || src_q[1].size() > 0) && c < 1000) begin tick(); c++; end
        check("t5_in_time", 32'(c < 1000), 32'd1);
        check("t5_next_grant", 32'(glog(1)), 32'd1);
        check("t5_bytes1", 32'(st_rd[1]), 32'd300);
        check("t5_pktend", 32'(st_pktend), 32'd2);
        auto_done[1] = 1'b0;

        // 6: reset mid-packet under backpressure, restart from source 0
        ready_rand = 1'b1;
        push(0, 600);
        push(1, 600);
        clear_stats();
        c = 0;
        while (st_rd[0] < 100 && c < 1000) begin tick(); c++; end
        check("t6_mid_in_time", 32'(c < 1000), 32'd1);
        do_reset();
        clear_stats();
        c = 0;
        while (grant_log.size() == 0 && c < 20) begin tick(); c++; end
        check("t6_restart_grant", 32'(glog(0)), 32'd0);

        // Randomized traffic: pushes, enable changes, stray done pulses
        for (int i = 0; i < 4000; i++) begin
            for (int n = 0; n < NSRC; n++) begin
                if (src_q[n].size() < 64 && $urandom_range(0, 15) == 0) push(n, $urandom_range(1, 40));
                if ($urandom_range(0, 63) == 0) pulse_done[n] = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) en_mask = NSRC'($urandom_range(0, (1 << NSRC) - 1));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
